// File: rtl/mips_gpio_pkg.sv
// Shared register-map offsets and reset values for the MIPS GPIO port.
package mips_gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_OUT  = 3'd0,
    GPIO_SET  = 3'd1,
    GPIO_CLR  = 3'd2,
    GPIO_TGL  = 3'd3,
    GPIO_IN   = 3'd4,
    GPIO_EDGE = 3'd5,
    GPIO_IE   = 3'd6,
    GPIO_RSVD = 3'd7
  } gpio_reg_e;

  // Reset values; sliced down to GPIO_WIDTH at the use site.
  localparam logic [31:0] OUT_RST   = 32'h0;
  localparam logic [31:0] EDGE_RST  = 32'h0;
  localparam logic [31:0] IE_RST    = 32'h0;
  localparam logic [31:0] SYNC_RST  = 32'h0;
  localparam logic [31:0] RDATA_RST = 32'h0;

endpackage

// File: rtl/mips_gpio_if.sv
// Core-side load/store bus into the GPIO port.
interface mips_gpio_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rd_valid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rd_valid);
endinterface

// File: rtl/mips_gpio_port_in_sync.sv
// Two-flop input synchronizer plus previous-sample register for rising-edge detect.
module gpio_in_sync
  import mips_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] sync,
  output logic [GPIO_WIDTH-1:0] rise
);
  logic [GPIO_WIDTH-1:0] sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= SYNC_RST[GPIO_WIDTH-1:0];
      sync2 <= SYNC_RST[GPIO_WIDTH-1:0];
      prev  <= SYNC_RST[GPIO_WIDTH-1:0];
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync = sync2;
  assign rise = sync2 & ~prev;
endmodule

// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO: output register with set/clr/toggle aliases, synchronized
// inputs, sticky W1C rising-edge flags and a masked edge interrupt.
module mips_gpio_port
  import mips_gpio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_gpio_if.slave            bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_data_out,
  output logic                  edge_irq
);
  logic [GPIO_WIDTH-1:0] out_q, edge_q, ie_q;
  logic [GPIO_WIDTH-1:0] out_next, edge_next, ie_next, clr_mask;
  logic [GPIO_WIDTH-1:0] in_sync, rise, wdat, rd_val;
  logic [DATA_WIDTH-1:0] rd_word, rdata_q;
  logic                  rd_valid_q, irq_q, hit, wr;
  gpio_reg_e             reg_sel;
  logic                  unused_bits;

  gpio_in_sync #(.GPIO_WIDTH(GPIO_WIDTH)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .gpio_in (gpio_in),
    .sync    (in_sync),
    .rise    (rise)
  );

  assign hit         = (bus.addr[ADDR_WIDTH-1:5] == '0);
  assign reg_sel     = gpio_reg_e'(bus.addr[4:2]);
  assign wdat        = bus.wdata[GPIO_WIDTH-1:0];
  assign wr          = bus.wr_en & hit;
  assign unused_bits = ^{bus.wdata[DATA_WIDTH-1:GPIO_WIDTH], bus.addr[1:0]};

  always_comb begin
    out_next = out_q;
    ie_next  = ie_q;
    clr_mask = '0;
    if (wr) begin
      case (reg_sel)
        GPIO_OUT:  out_next = wdat;
        GPIO_SET:  out_next = out_q | wdat;
        GPIO_CLR:  out_next = out_q & ~wdat;
        GPIO_TGL:  out_next = out_q ^ wdat;
        GPIO_EDGE: clr_mask = wdat;
        GPIO_IE:   ie_next  = wdat;
        default:   ;
      endcase
    end
    // A rise landing with a W1C of the same bit keeps the flag set.
    edge_next = (edge_q & ~clr_mask) | rise;
  end

  // Reads see pre-write register state, so a same-cycle store is not visible.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (reg_sel)
        GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: rd_val = out_q;
        GPIO_IN:   rd_val = in_sync;
        GPIO_EDGE: rd_val = edge_q;
        GPIO_IE:   rd_val = ie_q;
        default:   rd_val = '0;
      endcase
    end
    rd_word = '0;
    rd_word[GPIO_WIDTH-1:0] = rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= OUT_RST[GPIO_WIDTH-1:0];
      edge_q     <= EDGE_RST[GPIO_WIDTH-1:0];
      ie_q       <= IE_RST[GPIO_WIDTH-1:0];
      rdata_q    <= RDATA_RST[DATA_WIDTH-1:0];
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_next;
      edge_q     <= edge_next;
      ie_q       <= ie_next;
      rd_valid_q <= bus.rd_en;
      irq_q      <= |(edge_next & ie_next);
      if (bus.rd_en) rdata_q <= rd_word;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign gpio_data_out = out_q;
  assign edge_irq      = irq_q;
endmodule
